vregfile_control_mp: RTL and testbench
======================================

# vregfile_control_mp

Multi-port control register file for the vector unit, replacing the single-read/single-write control file. It provides NUM_RD_PORTS synchronous read ports, one general write port (c), and one post-increment port (d) for auto-incrementing base/stride registers. vl (clamped to MVL) and matmul_masks are exported as always-valid register outputs. The block sits between the vector decode stage and the vector lanes and memory unit.

## Interface
- WIDTH, 32, register width in bits
- NUMREGS, 32, number of control registers
- LOG2NUMREGS, 5, register index width
- NUM_RD_PORTS, 2, number of independent read ports (1..4)
- MVL, 64, maximum vector length; vl is clamped to this value
- VL_REG, 0, index of the vl register
- MASK_REG, 31, index of the matmul_masks register
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- a_reg  in  NUM_RD_PORTS*LOG2NUMREGS  read indices; port i uses slice i
- a_en  in  NUM_RD_PORTS  read enables; bit i enables port i
- a_readdataout  out  NUM_RD_PORTS*WIDTH  registered read data; slice i belongs to port i
- c_reg  in  LOG2NUMREGS  write index
- c_writedatain  in  WIDTH  write data
- c_we  in  1  write enable
- d_reg  in  LOG2NUMREGS  increment index
- d_incr  in  WIDTH  increment amount, two's complement
- d_we  in  1  increment enable
- vl  out  WIDTH  current vector length
- matmul_masks  out  WIDTH  current matmul lane masks
- vl_changed  out  1  one-cycle pulse, high the cycle after vl takes a different value
- d_dropped  out  1  one-cycle pulse, high the cycle after a d increment is discarded

## Operation
- Storage is NUMREGS×WIDTH flip-flops. On reset, all entries are 0 except MASK_REG, which is all ones. On reset, a_readdataout, vl_changed and d_dropped are 0, vl is 0, and matmul_masks is all ones.
- The c write stores c_writedatain at c_reg. If c_reg==VL_REG, the stored value is min(c_writedatain, MVL), compared as an unsigned value.
- The d increment does reg[d_reg] <= reg[d_reg] + d_incr, modulo 2^WIDTH. No saturation and no overflow flag.
- A d increment is discarded and d_dropped pulses when any of these hold: d_reg==VL_REG, d_reg==MASK_REG, or c_we && c_reg==d_reg. In the last case the c write wins.
- When c_we and d_we target different registers in the same cycle, both take effect.
- vl and matmul_masks are driven directly from their storage entries.
- vl_changed is asserted when a c write to VL_REG stores a value that differs from the old vl.
- Read port i, when a_en[i]=1, captures entry a_reg[i] into its output slice at the clock edge. When a_en[i]=0, the slice holds its previous value.
- Index values ≥ NUMREGS: a write is ignored and a read returns 0.

## Timing
- Read latency is 1 cycle: index presented in cycle N, data valid in cycle N+1.
- A write or increment in cycle N is visible on vl/matmul_masks in cycle N+1, and to reads issued in cycle N+1 or later.
- Read during write, same register and same cycle: the result depends on the macro (see Configuration).
- Back-to-back increments on the same register accumulate with no stall (1 per cycle).
- A reset asserted mid-operation immediately forces all state to reset values. Any write or increment in flight in that cycle is lost.

## Configuration
- VCTRL_RDW_BYPASS_EN defined: a read issued in the same cycle as a write or increment to the same register returns the new value. That is the clamped value for VL_REG, or the post-increment value for an increment.
- VCTRL_RDW_BYPASS_EN undefined: such a read returns the old value, which is old-data semantics.

## Structure
- Package vctrl_pkg holds:
  - default VL_REG and MASK_REG indices
  - MASK_RESET_VAL (all ones)
  - a function clamp_vl(data, mvl)
- Sub-module vctrl_read_port is instantiated NUM_RD_PORTS times. Each instance contains the index mux, the optional bypass compare/mux and the output register with enable.

## Test plan
- Reset with bypass compiled out, then read all registers on both ports: each returns 0 except index 31, which returns 0xFFFFFFFF. vl=0.
- Write c_reg=0 with 100 (MVL=64): vl=64 next cycle and vl_changed pulses once. Rewrite 64: no pulse.
- Write reg 5 = 0xFFFFFFFE, then d-increment reg 5 by 3 on two consecutive cycles: read returns 0x00000001, then 0x00000004.
- Same cycle: c writes reg 7 = 10 and d increments reg 7 by 5. Required: reg 7 = 10 and d_dropped pulses. Also d_reg=0 or 31: d_dropped pulses and the register is unchanged.
- Same cycle: write reg 3 = 0xAA while port 0 reads reg 3 (old value 0x55). With the macro defined, port 0 returns 0xAA. Without it, port 0 returns 0x55. Port 1 with a_en=0 holds its value.
- Assert reset mid-stream while a write to reg 31 = 0 is issued. Required: matmul_masks = 0xFFFFFFFF, and all read outputs are 0 while reset is high.

Source files
------------

// File: rtl/vctrl_pkg.sv
// Shared constants and helpers for the multi-port vector control register file.
package vctrl_pkg;

    localparam int unsigned VL_REG_DEF   = 0;
    localparam int unsigned MASK_REG_DEF = 31;
    localparam int unsigned CLAMP_W      = 64;

    localparam logic [CLAMP_W-1:0] MASK_RESET_VAL = '1;

    // Unsigned min(data, mvl); callers zero-extend to CLAMP_W and truncate the result.
    function automatic logic [CLAMP_W-1:0] clamp_vl(
        input logic [CLAMP_W-1:0] data,
        input logic [CLAMP_W-1:0] mvl
    );
        return (data > mvl) ? mvl : data;
    endfunction

endpackage

// File: rtl/vctrl_read_port.sv
// One synchronous read port: index mux, optional read-during-write bypass, enabled output register.
// Bypass is compiled in when VCTRL_RDW_BYPASS_EN is defined.
module vctrl_read_port
    import vctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUMREGS     = 32,
    parameter int unsigned LOG2NUMREGS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic [LOG2NUMREGS-1:0]   i_reg,
    input  logic [NUMREGS*WIDTH-1:0] i_regs_flat,
`ifdef VCTRL_RDW_BYPASS_EN
    input  logic                     i_c_apply,
    input  logic [LOG2NUMREGS-1:0]   i_c_reg,
    input  logic [WIDTH-1:0]         i_c_data,
    input  logic                     i_d_apply,
    input  logic [LOG2NUMREGS-1:0]   i_d_reg,
    input  logic [WIDTH-1:0]         i_d_data,
`endif
    output logic [WIDTH-1:0]         o_data
);

    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] r_data;

    always_comb begin
        w_data = '0;
        if (32'(i_reg) < NUMREGS) begin
            w_data = i_regs_flat[32'(i_reg)*WIDTH +: WIDTH];
        end
`ifdef VCTRL_RDW_BYPASS_EN
        // Same-cycle update wins over storage; c and d never both apply to one index.
        if (i_d_apply && (i_d_reg == i_reg)) begin
            w_data = i_d_data;
        end
        if (i_c_apply && (i_c_reg == i_reg)) begin
            w_data = i_c_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/vregfile_control_mp.sv
// Multi-port vector control register file: N read ports, a general write port and a post-increment port.
// Define VCTRL_RDW_BYPASS_EN to make same-cycle reads return the newly written value.
module vregfile_control_mp
    import vctrl_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NUMREGS      = 32,
    parameter int unsigned LOG2NUMREGS  = 5,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned MVL          = 64,
    parameter int unsigned VL_REG       = VL_REG_DEF,
    parameter int unsigned MASK_REG     = MASK_REG_DEF
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_RD_PORTS*LOG2NUMREGS-1:0] a_reg,
    input  logic [NUM_RD_PORTS-1:0]             a_en,
    output logic [NUM_RD_PORTS*WIDTH-1:0]       a_readdataout,
    input  logic [LOG2NUMREGS-1:0]              c_reg,
    input  logic [WIDTH-1:0]                    c_writedatain,
    input  logic                                c_we,
    input  logic [LOG2NUMREGS-1:0]              d_reg,
    input  logic [WIDTH-1:0]                    d_incr,
    input  logic                                d_we,
    output logic [WIDTH-1:0]                    vl,
    output logic [WIDTH-1:0]                    matmul_masks,
    output logic                                vl_changed,
    output logic                                d_dropped
);

    localparam logic [LOG2NUMREGS-1:0] VL_IDX   = LOG2NUMREGS'(VL_REG);
    localparam logic [LOG2NUMREGS-1:0] MASK_IDX = LOG2NUMREGS'(MASK_REG);

    logic [WIDTH-1:0]         r_regs      [NUMREGS];
    logic [WIDTH-1:0]         w_regs_next [NUMREGS];
    logic [NUMREGS*WIDTH-1:0] w_regs_flat;
    logic                     r_vl_changed;
    logic                     r_d_dropped;

    logic             w_c_valid;
    logic             w_c_apply;
    logic [WIDTH-1:0] w_c_data;
    logic             w_d_valid;
    logic             w_d_conflict;
    logic             w_d_apply;
    logic             w_d_drop;
    logic [WIDTH-1:0] w_d_old;
    logic [WIDTH-1:0] w_d_sum;
    logic             w_vl_changed;

    // Write/increment decode; a d increment colliding with vl, masks or a same-index c write is dropped.
    always_comb begin
        w_c_valid    = (32'(c_reg) < NUMREGS);
        w_c_apply    = c_we && w_c_valid;
        w_c_data     = c_writedatain;
        if (c_reg == VL_IDX) begin
            w_c_data = WIDTH'(clamp_vl(CLAMP_W'(c_writedatain), CLAMP_W'(MVL)));
        end
        w_d_valid    = (32'(d_reg) < NUMREGS);
        w_d_conflict = (d_reg == VL_IDX) || (d_reg == MASK_IDX) || (c_we && (c_reg == d_reg));
        w_d_drop     = d_we && w_d_conflict;
        w_d_apply    = d_we && w_d_valid && !w_d_conflict;
        w_d_old      = w_d_valid ? r_regs[d_reg] : '0;
        w_d_sum      = w_d_old + d_incr;
        w_vl_changed = w_c_apply && (c_reg == VL_IDX) && (w_c_data != r_regs[VL_REG]);
    end

    always_comb begin
        w_regs_next = r_regs;
        if (w_d_apply) begin
            w_regs_next[d_reg] = w_d_sum;
        end
        if (w_c_apply) begin
            w_regs_next[c_reg] = w_c_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUMREGS; i++) begin
                r_regs[i] <= (i == MASK_REG) ? WIDTH'(MASK_RESET_VAL) : '0;
            end
            r_vl_changed <= 1'b0;
            r_d_dropped  <= 1'b0;
        end else begin
            r_regs       <= w_regs_next;
            r_vl_changed <= w_vl_changed;
            r_d_dropped  <= w_d_drop;
        end
    end

    for (genvar g = 0; g < NUMREGS; g++) begin : g_flat
        assign w_regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
    end

    for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
        vctrl_read_port #(
            .WIDTH       (WIDTH),
            .NUMREGS     (NUMREGS),
            .LOG2NUMREGS (LOG2NUMREGS)
        ) u_rd (
            .clk         (clk),
            .reset       (reset),
            .i_en        (a_en[g]),
            .i_reg       (a_reg[g*LOG2NUMREGS +: LOG2NUMREGS]),
            .i_regs_flat (w_regs_flat),
`ifdef VCTRL_RDW_BYPASS_EN
            .i_c_apply   (w_c_apply),
            .i_c_reg     (c_reg),
            .i_c_data    (w_c_data),
            .i_d_apply   (w_d_apply),
            .i_d_reg     (d_reg),
            .i_d_data    (w_d_sum),
`endif
            .o_data      (a_readdataout[g*WIDTH +: WIDTH])
        );
    end

    assign vl           = r_regs[VL_REG];
    assign matmul_masks = r_regs[MASK_REG];
    assign vl_changed   = r_vl_changed;
    assign d_dropped    = r_d_dropped;

endmodule

// File: tb/tb_vregfile_control_mp.sv
// Directed self-checking bench for vregfile_control_mp (default parameters, two read ports).
module tb_vregfile_control_mp;

    logic        clk;
    logic        reset;
    logic [9:0]  a_reg;
    logic [1:0]  a_en;
    logic [63:0] a_readdataout;
    logic [4:0]  c_reg;
    logic [31:0] c_writedatain;
    logic        c_we;
    logic [4:0]  d_reg;
    logic [31:0] d_incr;
    logic        d_we;
    logic [31:0] vl;
    logic [31:0] matmul_masks;
    logic        vl_changed;
    logic        d_dropped;

    int n_cmp;
    int n_bad;

    vregfile_control_mp dut (
        .clk           (clk),
        .reset         (reset),
        .a_reg         (a_reg),
        .a_en          (a_en),
        .a_readdataout (a_readdataout),
        .c_reg         (c_reg),
        .c_writedatain (c_writedatain),
        .c_we          (c_we),
        .d_reg         (d_reg),
        .d_incr        (d_incr),
        .d_we          (d_we),
        .vl            (vl),
        .matmul_masks  (matmul_masks),
        .vl_changed    (vl_changed),
        .d_dropped     (d_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] port(input int p);
        logic [63:0] v;
        v = a_readdataout;
        return (p == 0) ? v[31:0] : v[63:32];
    endfunction

    // Issue one read on both ports, returning after the data has been captured.
    task automatic rd2(input logic [4:0] r0, input logic [4:0] r1);
        a_reg = {r1, r0};
        a_en  = 2'b11;
        tick();
        a_en  = 2'b00;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        c_reg = r; c_writedatain = d; c_we = 1'b1;
        tick();
        c_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_rdw;
        n_cmp = 0; n_bad = 0;
        reset = 1'b1;
        a_reg = '0; a_en = '0;
        c_reg = '0; c_writedatain = '0; c_we = 1'b0;
        d_reg = '0; d_incr = '0; d_we = 1'b0;
        tick(); tick();
        check("rst_port0", port(0), 32'h0);
        check("rst_port1", port(1), 32'h0);
        check("rst_vl", vl, 32'h0);
        check("rst_masks", matmul_masks, 32'hFFFF_FFFF);
        check("rst_vl_changed", 32'(vl_changed), 32'h0);
        check("rst_d_dropped", 32'(d_dropped), 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 32; i++) begin
            rd2(5'(i), 5'(31 - i));
            check($sformatf("init_p0_r%0d", i), port(0), (i == 31) ? 32'hFFFF_FFFF : 32'h0);
            check($sformatf("init_p1_r%0d", 31 - i), port(1), (i == 0) ? 32'hFFFF_FFFF : 32'h0);
        end

        // vl clamp and change pulse
        wr(5'd0, 32'd100);
        check("vl_clamped", vl, 32'd64);
        check("vl_changed_pulse", 32'(vl_changed), 32'h1);
        tick();
        check("vl_changed_clear", 32'(vl_changed), 32'h0);
        wr(5'd0, 32'd64);
        check("vl_same_no_pulse", 32'(vl_changed), 32'h0);
        check("vl_still_64", vl, 32'd64);

        // back-to-back increments with wraparound
        wr(5'd5, 32'hFFFF_FFFE);
        d_reg = 5'd5; d_incr = 32'd3; d_we = 1'b1;
        tick();
        check("inc1_no_drop", 32'(d_dropped), 32'h0);
        a_reg = {5'd0, 5'd5}; a_en = 2'b01;
        tick();
        d_we = 1'b0;
`ifdef VCTRL_RDW_BYPASS_EN
        check("inc_read_a", port(0), 32'h0000_0004);
`else
        check("inc_read_a", port(0), 32'h0000_0001);
`endif
        tick();
        a_en = 2'b00;
        check("inc_read_b", port(0), 32'h0000_0004);

        // c and d same register: c wins, d dropped
        c_reg = 5'd7; c_writedatain = 32'd10; c_we = 1'b1;
        d_reg = 5'd7; d_incr = 32'd5; d_we = 1'b1;
        tick();
        c_we = 1'b0; d_we = 1'b0;
        check("cd_same_drop", 32'(d_dropped), 32'h1);
        rd2(5'd7, 5'd7);
        check("cd_same_val", port(0), 32'd10);
        check("cd_drop_clear", 32'(d_dropped), 32'h0);

        d_reg = 5'd0; d_incr = 32'd1; d_we = 1'b1;
        tick();
        d_we = 1'b0;
        check("d_vl_drop", 32'(d_dropped), 32'h1);
        check("d_vl_unchanged", vl, 32'd64);
        d_reg = 5'd31; d_incr = 32'd1; d_we = 1'b1;
        tick();
        d_we = 1'b0;
        check("d_mask_drop", 32'(d_dropped), 32'h1);
        check("d_mask_unchanged", matmul_masks, 32'hFFFF_FFFF);

        // c and d different registers: both apply
        c_reg = 5'd8; c_writedatain = 32'h1234; c_we = 1'b1;
        d_reg = 5'd5; d_incr = 32'hFFFF_FFFF; d_we = 1'b1;
        tick();
        c_we = 1'b0; d_we = 1'b0;
        check("cd_diff_no_drop", 32'(d_dropped), 32'h0);
        rd2(5'd8, 5'd5);
        check("cd_diff_c", port(0), 32'h1234);
        check("cd_diff_d", port(1), 32'h3);

        // read during write, port 1 disabled must hold
        wr(5'd3, 32'h55);
        rd2(5'd8, 5'd8);
        a_reg = {5'd3, 5'd3}; a_en = 2'b01;
        c_reg = 5'd3; c_writedatain = 32'hAA; c_we = 1'b1;
        tick();
        c_we = 1'b0; a_en = 2'b00;
`ifdef VCTRL_RDW_BYPASS_EN
        exp_rdw = 32'hAA;
`else
        exp_rdw = 32'h55;
`endif
        check("rdw_port0", port(0), exp_rdw);
        check("rdw_port1_hold", port(1), 32'h1234);
        rd2(5'd3, 5'd0);
        check("rdw_after", port(0), 32'hAA);
        check("rdw_vl_read", port(1), 32'd64);

        // reset mid-stream discards an in-flight write to the mask register
        rd2(5'd3, 5'd8);
        c_reg = 5'd31; c_writedatain = 32'h0; c_we = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_p0", port(0), 32'h0);
        check("midrst_p1", port(1), 32'h0);
        check("midrst_masks", matmul_masks, 32'hFFFF_FFFF);
        tick();
        check("midrst_masks_edge", matmul_masks, 32'hFFFF_FFFF);
        check("midrst_vl", vl, 32'h0);
        c_we = 1'b0;
        reset = 1'b0;
        tick();
        rd2(5'd31, 5'd3);
        check("post_rst_r31", port(0), 32'hFFFF_FFFF);
        check("post_rst_r3", port(1), 32'h0);
        check("post_rst_masks", matmul_masks, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
